sdram_rr_arbiter: RTL
=====================

SDRAM_RR_ARBITER -- requirements
Module: sdram_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles to wait for avl_ack per transaction.
REQ-002 SHALL have port MAX10_CLK1_50, input, 1, 50 MHz clock; all logic on its rising edge.
REQ-003 SHALL have port Reset_h, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port wr_override, input, 1, loader-only mode; when high, read ports are not served.
REQ-005 SHALL have ports rd1_req/rd2_req, input, 1, read request held until matching ack.
REQ-006 SHALL have ports rd1_addr/rd2_addr, input, 25, word address.
REQ-007 SHALL have ports rd1_ack/rd2_ack, output, 1, one-cycle completion pulse.
REQ-008 SHALL have ports rd1_data/rd2_data, output, 16, read word, valid from the ack cycle until that port's next ack.
REQ-009 SHALL have ports wr_req, input, 1; wr_addr, input, 25; wr_data, input, 16; wr_ack, output, 1: write port with identical handshake.
REQ-010 SHALL have ports avl_addr, output, 26, byte address; avl_read, output, 1; avl_write, output, 1; avl_wrdata, output, 16; avl_rddata, input, 16; avl_ack, input, 1: Avalon bridge master side.
REQ-011 SHALL have port grant, output, 2, current owner (0 none, 1 rd1, 2 rd2, 3 wr).
REQ-012 SHALL have port timeout_err, output, 1, sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE.
REQ-014 IDLE: SHALL select one requester per cycle; with wr_override high only wr_req is eligible; otherwise rd1, rd2, wr are served round-robin starting after the last granted port (initially rd1 first).
REQ-015 On selection SHALL latch the port's address as {addr,1'b0} into avl_addr, latch wr_data for writes, set grant, update the round-robin pointer, and enter BUSY next cycle.
REQ-016 BUSY: SHALL hold avl_read (read ports) or avl_write (write port) high with stable avl_addr/avl_wrdata until avl_ack is sampled high.
REQ-017 On avl_ack in BUSY, SHALL deassert the command the next cycle, capture avl_rddata into the owning rdN_data (reads only), and enter DONE.
REQ-018 DONE: SHALL pulse exactly the owner's ack for one cycle, clear grant to 0, and return to IDLE; minimum spacing between back-to-back transactions is therefore 3 cycles plus Avalon latency.
REQ-019 avl_read and avl_write SHALL never be high simultaneously; no command is issued in IDLE or DONE.
REQ-020 A requester dropping its req during BUSY SHALL NOT abort the transaction; its ack still pulses.
REQ-021 wr_override rising during a read transaction SHALL NOT abort it; it takes effect at the next IDLE arbitration.
REQ-022 If avl_ack is not seen within TIMEOUT cycles of entering BUSY, SHALL drop the command, set timeout_err, leave rdN_data unchanged, and proceed to DONE (ack still pulses so requesters cannot hang).
REQ-023 timeout_err SHALL clear only on reset.
REQ-024 Address arithmetic: the 25-bit word address SHALL be shifted left by 1 with bit 0 forced to 0; no wrap or saturation.

Reset
REQ-025 Reset_h high SHALL immediately force state IDLE, all acks 0, avl_read/avl_write 0, avl_addr 0, avl_wrdata 0, rd1_data/rd2_data 0, grant 0, timeout_err 0, round-robin pointer to rd1-first, including mid-transaction.
REQ-026 The first arbitration SHALL occur on the first rising edge after Reset_h falls.

Verification
REQ-027 Single read: rd1_req, rd1_addr=0x000123, avl_ack after 4 cycles with avl_rddata=0xBEEF -> avl_addr=0x000246, avl_read high 4 cycles, rd1_ack one pulse, rd1_data=0xBEEF, grant 1 then 0.
REQ-028 Contention: rd1, rd2, wr held continuously, avl_ack 1-cycle latency -> grant order 1,2,3,1,2,3; no port starved; one ack per transaction.
REQ-029 Override: wr_override=1 with rd1_req and wr_req high -> only writes granted, rd1_ack stays 0; on wr_override=0, rd1 granted at next IDLE.
REQ-030 Timeout: TIMEOUT=8, rd2_req, avl_ack never asserted -> avl_read drops after 8 cycles, timeout_err=1, rd2_ack pulses, rd2_data unchanged.
REQ-031 Reset mid-op: Reset_h asserted during BUSY write -> avl_write, grant, acks 0 the same cycle; after release rd1 is granted first when all three request.
REQ-032 Request withdrawal: rd2_req dropped after grant -> transaction completes, rd2_ack pulses once, rd2_data updated.

Source files
------------

// File: rtl/sdram_rr_arbiter.sv
// rtl/sdram_rr_arbiter.sv - three-port round-robin arbiter onto an Avalon SDRAM bridge
//
// Ports:
//   MAX10_CLK1_50            : clock, all logic on the rising edge
//   Reset_h                  : asynchronous active-high reset
//   wr_override              : loader mode, only the write port is eligible
//   rd1_req/rd1_addr/rd1_ack/rd1_data : read port 1 (25-bit word address, 16-bit data)
//   rd2_req/rd2_addr/rd2_ack/rd2_data : read port 2
//   wr_req/wr_addr/wr_data/wr_ack     : write port
//   avl_addr/avl_read/avl_write/avl_wrdata/avl_rddata/avl_ack : Avalon master side
//   grant                    : current owner (0 none, 1 rd1, 2 rd2, 3 wr)
//   timeout_err              : sticky flag, set when avl_ack never arrived

module sdram_rr_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        MAX10_CLK1_50,
  input  logic        Reset_h,
  input  logic        wr_override,
  input  logic        rd1_req,
  input  logic [24:0] rd1_addr,
  output logic        rd1_ack,
  output logic [15:0] rd1_data,
  input  logic        rd2_req,
  input  logic [24:0] rd2_addr,
  output logic        rd2_ack,
  output logic [15:0] rd2_data,
  input  logic        wr_req,
  input  logic [24:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic [25:0] avl_addr,
  output logic        avl_read,
  output logic        avl_write,
  output logic [15:0] avl_wrdata,
  input  logic [15:0] avl_rddata,
  input  logic        avl_ack,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_RD1  = 2'd1;
  localparam logic [1:0] G_RD2  = 2'd2;
  localparam logic [1:0] G_WR   = 2'd3;

  // Timer counts BUSY cycles 0..TIMEOUT-1; the last value ends the wait.
  localparam int              TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [1:0]    rr_last;   // last granted port; reset to wr so rd1 wins first
  logic [TW-1:0] timer;
  logic [1:0]    pick;
  logic          el_rd1;
  logic          el_rd2;
  logic          el_wr;
  logic          finish;

  // Override masks the read ports out of arbitration only; a read already
  // in flight is unaffected because eligibility is only consulted in IDLE.
  assign el_rd1 = rd1_req & ~wr_override;
  assign el_rd2 = rd2_req & ~wr_override;
  assign el_wr  = wr_req;

  // Search order starts with the port after the last one granted.
  always_comb begin
    pick = G_NONE;
    case (rr_last)
      G_RD1: begin
        if (el_rd2)      pick = G_RD2;
        else if (el_wr)  pick = G_WR;
        else if (el_rd1) pick = G_RD1;
      end
      G_RD2: begin
        if (el_wr)       pick = G_WR;
        else if (el_rd1) pick = G_RD1;
        else if (el_rd2) pick = G_RD2;
      end
      default: begin
        if (el_rd1)      pick = G_RD1;
        else if (el_rd2) pick = G_RD2;
        else if (el_wr)  pick = G_WR;
      end
    endcase
  end

  // The transaction ends on avl_ack or when the wait budget is used up.
  assign finish = avl_ack | (timer == TMO_LAST);

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      state       <= IDLE;
      rr_last     <= G_WR;
      timer       <= '0;
      grant       <= G_NONE;
      avl_addr    <= '0;
      avl_read    <= 1'b0;
      avl_write   <= 1'b0;
      avl_wrdata  <= '0;
      rd1_data    <= '0;
      rd2_data    <= '0;
      rd1_ack     <= 1'b0;
      rd2_ack     <= 1'b0;
      wr_ack      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rd1_ack <= 1'b0;
      rd2_ack <= 1'b0;
      wr_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != G_NONE) begin
            grant   <= pick;
            rr_last <= pick;
            timer   <= '0;
            state   <= BUSY;
            case (pick)
              G_RD1: begin
                avl_addr <= {rd1_addr, 1'b0};
                avl_read <= 1'b1;
              end
              G_RD2: begin
                avl_addr <= {rd2_addr, 1'b0};
                avl_read <= 1'b1;
              end
              default: begin
                avl_addr   <= {wr_addr, 1'b0};
                avl_wrdata <= wr_data;
                avl_write  <= 1'b1;
              end
            endcase
          end
        end
        BUSY: begin
          if (finish) begin
            avl_read  <= 1'b0;
            avl_write <= 1'b0;
            state     <= DONE;
            // Ack is raised here so it is visible exactly during DONE.
            rd1_ack   <= (grant == G_RD1);
            rd2_ack   <= (grant == G_RD2);
            wr_ack    <= (grant == G_WR);
            if (avl_ack) begin
              if (grant == G_RD1) rd1_data <= avl_rddata;
              if (grant == G_RD2) rd2_data <= avl_rddata;
            end else begin
              // Timed out: read data is left untouched.
              timeout_err <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          grant <= G_NONE;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
